// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if : requester, response and memory signals of the dmem arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  // Requesters plus memory side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter : two-port fixed-priority arbiter for the single-port data memory
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int WORDS    = 64,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_arb,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0]  c_MAX_WAIT = 8'(MAX_WAIT);
  localparam logic [29:0] c_WORDS    = 30'(WORDS);

  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        rvalid0_q, rvalid0_d;
  logic        err0_q, err0_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        w_force_p1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_we;
  logic        w_legal;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  always_comb begin
    w_force_p1 = bus.p1_req && (wait_cnt_q == c_MAX_WAIT);
    w_gnt0     = !rst_arb && bus.p0_req && !w_force_p1;
    w_gnt1     = !rst_arb && bus.p1_req && (!bus.p0_req || w_force_p1);

    // Port 0 values stay on the bus when nobody is granted
    w_addr  = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
    w_wdata = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;
    w_we    = w_gnt1 ? bus.p1_we    : bus.p0_we;

    w_legal = (w_addr[1:0] == 2'b00) && (w_addr[31:2] < c_WORDS);
    w_rdata = (w_legal && !w_we) ? bus.mem_read_data : 32'h0;

    wait_cnt_d = 8'h00;
    if (bus.p1_req && !w_gnt1) begin
      wait_cnt_d = (wait_cnt_q < c_MAX_WAIT) ? wait_cnt_q + 8'h01 : wait_cnt_q;
    end

    rvalid0_d = w_gnt0;
    err0_d    = w_gnt0 && !w_legal;
    rdata0_d  = w_gnt0 ? w_rdata : 32'h0;
    rvalid1_d = w_gnt1;
    err1_d    = w_gnt1 && !w_legal;
    rdata1_d  = w_gnt1 ? w_rdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst_arb) begin
      wait_cnt_q <= 8'h00;
      rvalid0_q  <= 1'b0;
      err0_q     <= 1'b0;
      rdata0_q   <= 32'h0;
      rvalid1_q  <= 1'b0;
      err1_q     <= 1'b0;
      rdata1_q   <= 32'h0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid0_q  <= rvalid0_d;
      err0_q     <= err0_d;
      rdata0_q   <= rdata0_d;
      rvalid1_q  <= rvalid1_d;
      err1_q     <= err1_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.p0_gnt = w_gnt0;
  assign bus.p1_gnt = w_gnt1;

  assign bus.mem_address      = w_addr;
  assign bus.mem_write_data   = w_wdata;
  assign bus.mem_write_enable = (w_gnt0 || w_gnt1) && w_we && w_legal;

  // Responses are masked during reset so a response in flight is dropped at once
  assign bus.p0_rvalid = rvalid0_q && !rst_arb;
  assign bus.p0_err    = err0_q && !rst_arb;
  assign bus.p0_rdata  = rst_arb ? 32'h0 : rdata0_q;
  assign bus.p1_rvalid = rvalid1_q && !rst_arb;
  assign bus.p1_err    = err1_q && !rst_arb;
  assign bus.p1_rdata  = rst_arb ? 32'h0 : rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic clk;
  logic rst_arb;
  int   errors;
  int   checks;

  logic [31:0] mem [64];

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .WORDS    (64),
    .MAX_WAIT (8)
  ) dut (
    .clk     (clk),
    .rst_arb (rst_arb),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[7:2]];

  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  task automatic test_reset;
    rst_arb = 1'b1;
    set0(1'b1, 1'b1, 32'h10, 32'h1);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable} !== 3'b000) begin
        errors++;
        $display("FAIL reset_gnt cyc%0d: got gnt0/gnt1/we=%b%b%b want 000", c,
                 bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable);
      end
      checks++;
      if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata, bus.p1_rvalid, bus.p1_err, bus.p1_rdata} !== 68'h0) begin
        errors++;
        $display("FAIL reset_resp cyc%0d: got rv0=%b e0=%b rd0=%h rv1=%b e1=%b rd1=%h want all 0", c,
                 bus.p0_rvalid, bus.p0_err, bus.p0_rdata, bus.p1_rvalid, bus.p1_err, bus.p1_rdata);
      end
    end
    tick();
    rst_arb = 1'b0;
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if ({bus.p0_rvalid, mem[4]} !== {1'b0, 32'hA000_0004}) begin
      errors++;
      $display("FAIL reset_nowrite: got rv0=%b mem[4]=%h want 0 a0000004", bus.p0_rvalid, mem[4]);
    end
  endtask

  task automatic test_single;
    tick();
    set0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    #1;
    checks++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable, bus.mem_address, bus.mem_write_data}
        !== {3'b101, 32'h10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_wr_drive: got gnt0=%b gnt1=%b we=%b addr=%h wd=%h want 1 0 1 10 deadbeef",
               bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable, bus.mem_address, bus.mem_write_data);
    end
    tick();
    set0(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checks++;
    if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata, bus.p0_gnt, bus.mem_write_enable}
        !== {2'b10, 32'h0, 2'b10}) begin
      errors++;
      $display("FAIL single_wr_ack: got rv=%b err=%b rd=%h gnt=%b we=%b want 1 0 0 1 0",
               bus.p0_rvalid, bus.p0_err, bus.p0_rdata, bus.p0_gnt, bus.mem_write_enable);
    end
    tick();
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_rd: got rv=%b err=%b rd=%h want 1 0 deadbeef",
               bus.p0_rvalid, bus.p0_err, bus.p0_rdata);
    end
    checks++;
    if ({bus.p1_rvalid, bus.p1_err, bus.p1_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL single_p1_quiet: got rv=%b err=%b rd=%h want 0 0 0",
               bus.p1_rvalid, bus.p1_err, bus.p1_rdata);
    end
    tick();
    #1;
    checks++;
    if (bus.p0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_rv_pulse: got rv=%b want 0", bus.p0_rvalid);
    end
  endtask

  task automatic test_contention;
    tick();
    set0(1'b1, 1'b0, 32'h0, 32'h0);
    set1(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    for (int k = 0; k < 27; k++) begin
      logic        exp_g1;
      logic        exp_rv1;
      logic [31:0] exp_rd1;
      if (k > 0) tick();
      exp_g1  = (k % 9) == 8;
      exp_rv1 = (k > 0) && (((k - 1) % 9) == 8);
      exp_rd1 = exp_rv1 ? 32'hA000_0001 : 32'h0;
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.p1_rvalid, bus.p1_rdata} !== {!exp_g1, exp_g1, exp_rv1, exp_rd1}) begin
        errors++;
        $display("FAIL contention k=%0d: got gnt0=%b gnt1=%b rv1=%b rd1=%h want %b %b %b %h", k,
                 bus.p0_gnt, bus.p1_gnt, bus.p1_rvalid, bus.p1_rdata, !exp_g1, exp_g1, exp_rv1, exp_rd1);
      end
    end
    tick();
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_errors;
    tick();
    set1(1'b1, 1'b0, 32'h102, 32'h0);
    #1;
    checks++;
    if ({bus.p1_gnt, bus.p0_gnt, bus.mem_write_enable} !== 3'b100) begin
      errors++;
      $display("FAIL err_rd102_gnt: got gnt1=%b gnt0=%b we=%b want 1 0 0",
               bus.p1_gnt, bus.p0_gnt, bus.mem_write_enable);
    end
    tick();
    set1(1'b1, 1'b0, 32'h12, 32'h0);
    #1;
    checks++;
    if ({bus.p1_rvalid, bus.p1_err, bus.p1_rdata, bus.p1_gnt} !== {2'b11, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL err_rd102_resp: got rv=%b err=%b rd=%h gnt=%b want 1 1 0 1",
               bus.p1_rvalid, bus.p1_err, bus.p1_rdata, bus.p1_gnt);
    end
    tick();
    set1(1'b1, 1'b1, 32'h100, 32'h1234_5678);
    #1;
    checks++;
    if ({bus.p1_rvalid, bus.p1_err, bus.p1_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL err_rd12_resp: got rv=%b err=%b rd=%h want 1 1 0",
               bus.p1_rvalid, bus.p1_err, bus.p1_rdata);
    end
    checks++;
    if ({bus.p1_gnt, bus.mem_write_enable} !== 2'b10) begin
      errors++;
      $display("FAIL err_wr100_drive: got gnt=%b we=%b want 1 0", bus.p1_gnt, bus.mem_write_enable);
    end
    tick();
    set1(1'b1, 1'b1, 32'h11, 32'hBAD0_BAD0);
    #1;
    checks++;
    if ({bus.p1_rvalid, bus.p1_err, bus.p1_rdata, bus.mem_write_enable} !== {2'b11, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL err_wr100_resp: got rv=%b err=%b rd=%h we=%b want 1 1 0 0",
               bus.p1_rvalid, bus.p1_err, bus.p1_rdata, bus.mem_write_enable);
    end
    tick();
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    set0(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if ({bus.p1_rvalid, bus.p1_err, bus.p0_rvalid, bus.p0_err} !== 4'b1100) begin
      errors++;
      $display("FAIL err_wr11_resp: got rv1=%b err1=%b rv0=%b err0=%b want 1 1 0 0",
               bus.p1_rvalid, bus.p1_err, bus.p0_rvalid, bus.p0_err);
    end
    tick();
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata, mem[4]} !== {2'b10, 32'hA000_0000, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL err_mem_intact: got rv0=%b err0=%b rd0=%h mem[4]=%h want 1 0 a0000000 deadbeef",
               bus.p0_rvalid, bus.p0_err, bus.p0_rdata, mem[4]);
    end
  endtask

  task automatic test_back_to_back;
    tick();
    set0(1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A);
    #1;
    checks++;
    if ({bus.p0_gnt, bus.mem_write_enable} !== 2'b11) begin
      errors++;
      $display("FAIL raw_wr: got gnt=%b we=%b want 1 1", bus.p0_gnt, bus.mem_write_enable);
    end
    tick();
    set0(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    checks++;
    if ({bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL raw_rd_issue: got gnt=%b rv=%b rd=%h want 1 1 0",
               bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata);
    end
    tick();
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata} !== {2'b10, 32'h5A5A_5A5A}) begin
      errors++;
      $display("FAIL raw_rd_data: got rv=%b err=%b rd=%h want 1 0 5a5a5a5a",
               bus.p0_rvalid, bus.p0_err, bus.p0_rdata);
    end
  endtask

  task automatic test_reset_mid;
    tick();
    set1(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    checks++;
    if (bus.p1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: got gnt1=%b want 1", bus.p1_gnt);
    end
    tick();
    rst_arb = 1'b1;
    set0(1'b1, 1'b0, 32'h0, 32'h0);
    set1(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    checks++;
    if ({bus.p1_rvalid, bus.p1_rdata, bus.p0_gnt, bus.p1_gnt} !== 35'h0) begin
      errors++;
      $display("FAIL rstmid_drop: got rv1=%b rd1=%h gnt0=%b gnt1=%b want 0 0 0 0",
               bus.p1_rvalid, bus.p1_rdata, bus.p0_gnt, bus.p1_gnt);
    end
    tick();
    rst_arb = 1'b0;
    #1;
    checks++;
    if ({bus.p1_rvalid, bus.p0_gnt, bus.p1_gnt} !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_after: got rv1=%b gnt0=%b gnt1=%b want 0 1 0",
               bus.p1_rvalid, bus.p0_gnt, bus.p1_gnt);
    end
    for (int k = 1; k < 9; k++) begin
      logic exp_g1;
      tick();
      exp_g1 = (k == 8);
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {!exp_g1, exp_g1}) begin
        errors++;
        $display("FAIL rstmid_wait k=%0d: got gnt0=%b gnt1=%b want %b %b", k,
                 bus.p0_gnt, bus.p1_gnt, !exp_g1, exp_g1);
      end
    end
    tick();
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_single();
    test_contention();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/DMA loader).
- Grants at most one access per cycle and drives the memory's address, write data and write enable.
- Registers the read data and returns it to the granted requester one cycle later.
- Blocks misaligned or out-of-range accesses and reports them as errors. Prevents port 1 starvation with a wait counter.

Parameters:
- WORDS, 64, memory depth in 32-bit words. Must match the attached data memory.
- MAX_WAIT, 8, consecutive cycles port 1 may be denied before it is force-granted (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_arb  in  1  synchronous active-high reset
- p0_req  in  1  port 0 access request, held until p0_gnt
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_gnt  out  1  port 0 request accepted this cycle (combinational)
- p0_rvalid  out  1  port 0 response valid (registered)
- p0_rdata  out  32  port 0 read data (registered)
- p0_err  out  1  port 0 access faulted (registered, qualifies p0_rvalid)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write data
- mem_write_enable  out  1  to memory write enable
- mem_read_data  in  32  from memory, combinational read of mem_address

Behaviour:
- Reset (while rst_arb=1):
  - All outputs 0: gnt, rvalid, err, rdata, mem_write_enable.
  - wait_cnt=0.
  - No grant is issued and no write occurs, even if a request is pending.
- Reset mid-transaction: a response due next cycle is dropped (rvalid stays 0). The requester must re-issue.
- Arbitration, evaluated each cycle N with rst_arb=0:
  - Only one requester active: it is granted.
  - Both active: port 0 is granted, unless wait_cnt == MAX_WAIT, in which case port 1 is granted.
  - Exactly one gnt is high for one cycle per accepted request.
  - The requester drops or changes its request after seeing gnt.
- wait_cnt (8-bit):
  - Increments when p1_req=1 and p1_gnt=0.
  - Clears to 0 when p1_gnt=1 or p1_req=0.
  - Saturates at MAX_WAIT.
- Memory drive in cycle N:
  - mem_address and mem_write_data come from the granted port.
  - With no grant, they hold the port 0 values and mem_write_enable=0.
  - mem_write_enable = granted port's we AND access legal. The write commits at the end of cycle N.
- Legality rules:
  - addr[1:0] must be 2'b00.
  - addr[31:2] must be < WORDS.
  - Otherwise the access is an error: the grant is still issued, no write occurs, and read data is forced to 0.
- Response:
  - In cycle N+1 the granted port sees rvalid=1 for exactly one cycle.
  - rdata = mem_read_data sampled at the end of N for legal reads; 0 for writes and errors.
  - err=1 for illegal accesses, otherwise 0.
  - rvalid is also pulsed for writes, as a write acknowledge.
  - The non-granted port's rvalid, err and rdata stay 0.
- Back-to-back: a new grant in cycle N+1 is allowed while the N response is presented. Throughput is 1 access/cycle.
- Read-after-write, same address, consecutive cycles: the second read returns the newly written data, because the write commits before the read cycle.
- Address 0 is forwarded unmodified. Arbiter legality does not special-case it.

Test Plan:
- Reset: assert rst_arb 2 cycles with p0_req=1 -> p0_gnt=0, mem_write_enable=0, all rvalid/err/rdata=0.
- Single access: p0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> p0_rvalid pulses in the cycle after each gnt; the read returns p0_rdata=0xDEADBEEF, err=0.
- Contention: both ports request continuously with MAX_WAIT=8 -> p0 granted 8 cycles, p1 granted on the 9th, then wait_cnt restarts from 0; the pattern repeats every 9 cycles.
- Errors: p1 reads 0x102 (misaligned), then writes 0x100 (word 64, out of range for WORDS=64) -> both granted, p1_err=1, p1_rdata=0, mem_write_enable=0, memory unchanged.
- Back-to-back RAW: p0 writes 0x5A5A5A5A to 0x20 in cycle N and reads 0x20 in N+1 -> rdata=0x5A5A5A5A in N+2.
- Reset mid-operation: p1 read granted in cycle N, rst_arb=1 in N+1 -> p1_rvalid=0 in N+1 and N+2, and wait_cnt=0 afterwards.
